// File: rtl/pci_bus_arbiter.sv
// Round-robin central arbiter for the shared PCI bus: one active-low grant at a
// time, never granting while FRAME#/IRDY# show a transaction, with unused-grant timeout.
module pci_bus_arbiter #(
    parameter int NUM_DEV = 4,
    parameter int OWNER_W = 2,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_DEV-1:0] req_n,
    input  logic               frame_n,
    input  logic               irdy_n,
    output logic [NUM_DEV-1:0] gnt_n,
    output logic [OWNER_W-1:0] owner,
    output logic               owner_valid,
    output logic               bus_busy,
    output logic               timeout_err
);

    localparam int unsigned NDEV      = NUM_DEV;
    localparam logic [7:0]  TIMER_MAX = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        BUSY,
        RELEASE
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_DEV-1:0] gnt_n_q, gnt_n_d;
    logic [OWNER_W-1:0] owner_q, owner_d;
    logic [OWNER_W-1:0] last_q, last_d;
    logic               owner_valid_q, owner_valid_d;
    logic               bus_busy_q, bus_busy_d;
    logic               timeout_err_q, timeout_err_d;
    logic [7:0]         timer_q, timer_d;

    logic               bus_idle;
    logic               frame_act;
    logic               owner_req;
    logic               pick_found;
    logic [OWNER_W-1:0] pick_idx;
    logic [OWNER_W-1:0] cand;

    // Only an exact 0 counts as asserted; x/z on any of these reads as inactive.
    always_comb begin
        bus_idle  = 1'b0;
        frame_act = 1'b0;
        owner_req = 1'b0;
        if (frame_n == 1'b1 && irdy_n == 1'b1) bus_idle = 1'b1;
        if (frame_n == 1'b0) frame_act = 1'b1;
        if (req_n[owner_q] == 1'b0) owner_req = 1'b1;
    end

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned off = 1; off <= NDEV; off++) begin
            cand = OWNER_W'((32'(last_q) + off) % NDEV);
            if (!pick_found && req_n[cand] == 1'b0) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        gnt_n_d       = '1;
        owner_d       = owner_q;
        last_d        = last_q;
        owner_valid_d = owner_valid_q;
        timer_d       = timer_q;
        timeout_err_d = 1'b0;
        bus_busy_d    = 1'b0;
        if (frame_n == 1'b0 || irdy_n == 1'b0) bus_busy_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (bus_idle && pick_found) begin
                    gnt_n_d[pick_idx] = 1'b0;
                    owner_d           = pick_idx;
                    last_d            = pick_idx;
                    owner_valid_d     = 1'b1;
                    timer_d           = '0;
                    state_d           = GRANT;
                end
            end
            // Frame beats withdrawal beats timeout when they land on the same edge.
            GRANT: begin
                if (frame_act) begin
                    state_d = BUSY;
                end else if (!owner_req) begin
                    state_d = RELEASE;
                end else if (timer_q == TIMER_MAX) begin
                    timeout_err_d = 1'b1;
                    state_d       = RELEASE;
                end else begin
                    gnt_n_d = gnt_n_q;
                    timer_d = timer_q + 8'd1;
                end
            end
            BUSY: begin
                if (bus_idle) state_d = RELEASE;
            end
            RELEASE: begin
                owner_valid_d = 1'b0;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            gnt_n_q       <= '1;
            owner_q       <= '0;
            last_q        <= OWNER_W'(NUM_DEV - 1);
            owner_valid_q <= 1'b0;
            bus_busy_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            timer_q       <= '0;
        end else begin
            state_q       <= state_d;
            gnt_n_q       <= gnt_n_d;
            owner_q       <= owner_d;
            last_q        <= last_d;
            owner_valid_q <= owner_valid_d;
            bus_busy_q    <= bus_busy_d;
            timeout_err_q <= timeout_err_d;
            timer_q       <= timer_d;
        end
    end

    assign gnt_n       = gnt_n_q;
    assign owner       = owner_q;
    assign owner_valid = owner_valid_q;
    assign bus_busy    = bus_busy_q;
    assign timeout_err = timeout_err_q;

endmodule
